// File: rtl/mem_arbiter.sv
// Two-client arbiter for the main-memory line port: icache and dcache miss handlers
// take turns (round-robin on ties), one outstanding memory transaction at a time.
module mem_arbiter #(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 128,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req_in,
    input  logic [ADDR_BITS-1:0] ic_addr_in,
    output logic                 ic_resp_valid_out,
    output logic [LINE_BITS-1:0] ic_rdata_out,
    input  logic                 dc_req_in,
    input  logic                 dc_we_in,
    input  logic [ADDR_BITS-1:0] dc_addr_in,
    input  logic [LINE_BITS-1:0] dc_wdata_in,
    output logic                 dc_resp_valid_out,
    output logic [LINE_BITS-1:0] dc_rdata_out,
    output logic                 mem_req_out,
    output logic                 mem_we_out,
    output logic [ADDR_BITS-1:0] mem_addr_out,
    output logic [LINE_BITS-1:0] mem_wdata_out,
    input  logic                 mem_resp_valid_in,
    input  logic [LINE_BITS-1:0] mem_rdata_in,
    output logic [CNT_BITS-1:0]  ic_grants_out,
    output logic [CNT_BITS-1:0]  dc_grants_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t                 state_r;
    state_t                 state_s;
    owner_t                 owner_r;
    owner_t                 last_owner_r;
    owner_t                 grant_owner_s;
    logic                   grant_s;
    logic                   fill_s;

    logic                   mem_req_r;
    logic                   mem_we_r;
    logic [ADDR_BITS-1:0]   mem_addr_r;
    logic [LINE_BITS-1:0]   mem_wdata_r;
    logic                   ic_resp_r;
    logic                   dc_resp_r;
    logic [LINE_BITS-1:0]   ic_rdata_r;
    logic [LINE_BITS-1:0]   dc_rdata_r;
    logic [CNT_BITS-1:0]    ic_grants_r;
    logic [CNT_BITS-1:0]    dc_grants_r;

    // Grant decision: requests are only looked at in IDLE; a tie goes to whoever did not win last
    always_comb begin
        grant_s       = 1'b0;
        grant_owner_s = OWN_IC;
        if (state_r == ST_IDLE) begin
            if (ic_req_in && dc_req_in) begin
                grant_s       = 1'b1;
                grant_owner_s = (last_owner_r == OWN_IC) ? OWN_DC : OWN_IC;
            end else if (dc_req_in) begin
                grant_s       = 1'b1;
                grant_owner_s = OWN_DC;
            end else if (ic_req_in) begin
                grant_s       = 1'b1;
                grant_owner_s = OWN_IC;
            end else begin
                grant_s       = 1'b0;
                grant_owner_s = OWN_IC;
            end
        end else begin
            grant_s       = 1'b0;
            grant_owner_s = OWN_IC;
        end
    end

    // Next-state logic; memory responses outside WAIT fall through untouched
    always_comb begin
        state_s = state_r;
        fill_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid_in) begin
                    fill_s  = 1'b1;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction latches, response pulses, fill data and grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r      <= OWN_IC;
            last_owner_r <= OWN_IC;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_BITS{1'b0}};
            mem_wdata_r  <= {LINE_BITS{1'b0}};
            ic_resp_r    <= 1'b0;
            dc_resp_r    <= 1'b0;
            ic_rdata_r   <= {LINE_BITS{1'b0}};
            dc_rdata_r   <= {LINE_BITS{1'b0}};
            ic_grants_r  <= {CNT_BITS{1'b0}};
            dc_grants_r  <= {CNT_BITS{1'b0}};
        end else begin
            ic_resp_r <= 1'b0;
            dc_resp_r <= 1'b0;
            if (grant_s) begin
                owner_r      <= grant_owner_s;
                last_owner_r <= grant_owner_s;
                mem_req_r    <= 1'b1;
                if (grant_owner_s == OWN_DC) begin
                    mem_we_r    <= dc_we_in;
                    mem_addr_r  <= dc_addr_in;
                    mem_wdata_r <= dc_wdata_in;
                    dc_grants_r <= dc_grants_r + CNT_BITS'(1);
                end else begin
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= ic_addr_in;
                    mem_wdata_r <= {LINE_BITS{1'b0}};
                    ic_grants_r <= ic_grants_r + CNT_BITS'(1);
                end
            end
            if (fill_s) begin
                mem_req_r <= 1'b0;
                // Write-backs return an all-zero line to the owner
                if (owner_r == OWN_DC) begin
                    dc_resp_r  <= 1'b1;
                    dc_rdata_r <= mem_we_r ? {LINE_BITS{1'b0}} : mem_rdata_in;
                end else begin
                    ic_resp_r  <= 1'b1;
                    ic_rdata_r <= mem_we_r ? {LINE_BITS{1'b0}} : mem_rdata_in;
                end
            end
        end
    end

    assign mem_req_out       = mem_req_r;
    assign mem_we_out        = mem_we_r;
    assign mem_addr_out      = mem_addr_r;
    assign mem_wdata_out     = mem_wdata_r;
    assign ic_resp_valid_out = ic_resp_r;
    assign dc_resp_valid_out = dc_resp_r;
    assign ic_rdata_out      = ic_rdata_r;
    assign dc_rdata_out      = dc_rdata_r;
    assign ic_grants_out     = ic_grants_r;
    assign dc_grants_out     = dc_grants_r;

endmodule
